// File: rtl/beep_pkg.sv
// Shared beeper definitions: note periods at 100 MHz, sound-effect tone table,
// arbiter state encoding and small slot helpers used by the arbiter and music modules.
package beep_pkg;

   localparam int unsigned PERIOD_W = 20;

   localparam logic [PERIOD_W-1:0] C4  = 20'd382219;
   localparam logic [PERIOD_W-1:0] D4  = 20'd340530;
   localparam logic [PERIOD_W-1:0] E4  = 20'd303370;
   localparam logic [PERIOD_W-1:0] F4  = 20'd286344;
   localparam logic [PERIOD_W-1:0] G4  = 20'd255102;
   localparam logic [PERIOD_W-1:0] A4  = 20'd227273;
   // A fourteen octaves above A0 (~450 kHz), used as a near-ultrasonic click
   localparam logic [PERIOD_W-1:0] A14 = 20'd222;

   localparam logic [PERIOD_W-1:0] SFX_TONE [0:3] = '{A4, G4, E4, C4};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      PLAY  = 2'd2,
      GAP   = 2'd3
   } beep_state_e;

   function automatic logic [1:0] lowest_slot(input logic [3:0] v);
      logic [1:0] s;
      s = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (v[i]) s = 2'(i);
      return s;
   endfunction

   function automatic logic [3:0] slot_onehot(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

   function automatic logic [3:0] below_mask(input logic [1:0] s);
      return slot_onehot(s) - 4'd1;
   endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone generator: counts 0..period-1 and drives wave high for the
// upper half of the count, giving a 50 % duty cycle.
module beep_tone_gen
   import beep_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                restart,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                wave
);

   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W:0]   w_cnt_inc;

   assign w_cnt_inc = {1'b0, r_cnt} + (PERIOD_W+1)'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (restart)
         r_cnt <= '0;
      else if (en)
         r_cnt <= (w_cnt_inc >= {1'b0, period}) ? '0 : w_cnt_inc[PERIOD_W-1:0];
   end

   // A zero period would otherwise read as permanently high
   assign wave = (period != '0) && (r_cnt >= (period >> 1));

endmodule

// File: rtl/beep_arbiter.sv
// Sound-effect arbiter: grants one of four prioritised requests, plays its tone,
// then inserts a silent gap. Define BEEP_ARB_PREEMPT_EN to let higher-priority slots abort a play.
//
// state | meaning
// IDLE  | music passthrough, waiting for a pending request
// GRANT | one cycle: ack the slot, load duration, restart tone
// PLAY  | tone output for SFX_DUR_CYC cycles
// GAP   | silence for GAP_CYCLES cycles
module beep_arbiter
   import beep_pkg::*;
#(
   parameter int SFX_DUR_CYC      = 10_000_000,
   parameter int GAP_CYCLES       = 1_000_000,
   parameter int TONE_SCALE_SHIFT = 0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       mute,
   input  logic       music_beep,
   input  logic [3:0] sfx_req,
   output logic [3:0] sfx_ack,
   output logic [3:0] sfx_done,
   output logic       sfx_busy,
   output logic       beep
);

   localparam logic [31:0] DUR_LOAD = 32'(SFX_DUR_CYC - 1);
   localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

   beep_state_e         r_state;
   logic [31:0]         r_cnt;
   logic [1:0]          r_cur_slot;
   logic [3:0]          r_pending;
   logic [3:0]          r_ack;
   logic [3:0]          r_done;
   logic                r_beep;

   logic [3:0]          w_req;
   logic [3:0]          w_cand;
   logic [1:0]          w_cand_slot;
   logic [PERIOD_W-1:0] w_period;
   logic                w_wave;
   logic                w_play_last;
   logic                w_preempt;

   assign w_req       = mute ? 4'd0 : sfx_req;
   assign w_cand      = r_pending | w_req;
   assign w_cand_slot = lowest_slot(w_cand);
   assign w_period    = SFX_TONE[r_cur_slot] >> TONE_SCALE_SHIFT;
   assign w_play_last = (r_cnt == '0);

`ifdef BEEP_ARB_PREEMPT_EN
   // The last play cycle already carries the done pulse, so it is never aborted
   assign w_preempt = (r_state == PLAY) && !w_play_last
                      && ((w_cand & below_mask(r_cur_slot)) != 4'd0);
`else
   assign w_preempt = 1'b0;
`endif

   beep_tone_gen u_tone (
      .clk     (clk),
      .rst     (rst),
      .restart (r_state == GRANT),
      .en      (r_state == PLAY),
      .period  (w_period),
      .wave    (w_wave)
   );

   // The granted slot stays pending until its GRANT cycle so a same-cycle request re-arms it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pending <= '0;
      else if (mute)
         r_pending <= '0;
      else if (r_state == GRANT)
         r_pending <= (r_pending & ~slot_onehot(r_cur_slot)) | w_req;
      else
         r_pending <= r_pending | w_req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_cur_slot <= '0;
         r_ack      <= '0;
         r_done     <= '0;
         r_beep     <= 1'b0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         if (mute) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_beep  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_cand != 4'd0) begin
                     r_state    <= GRANT;
                     r_cur_slot <= w_cand_slot;
                     r_ack      <= slot_onehot(w_cand_slot);
                     r_beep     <= 1'b0;
                  end else begin
                     r_beep <= music_beep;
                  end
               end
               GRANT: begin
                  r_state <= PLAY;
                  r_cnt   <= DUR_LOAD;
                  r_beep  <= 1'b0;
                  if (SFX_DUR_CYC == 1)
                     r_done <= slot_onehot(r_cur_slot);
               end
               PLAY: begin
                  if (w_preempt) begin
                     r_state    <= GRANT;
                     r_cur_slot <= w_cand_slot;
                     r_ack      <= slot_onehot(w_cand_slot);
                     r_beep     <= 1'b0;
                  end else if (w_play_last) begin
                     if (GAP_CYCLES == 0) begin
                        r_state <= IDLE;
                        r_beep  <= music_beep;
                     end else begin
                        r_state <= GAP;
                        r_cnt   <= GAP_LOAD;
                        r_beep  <= 1'b0;
                     end
                  end else begin
                     r_cnt  <= r_cnt - 32'd1;
                     r_beep <= w_wave;
                     if (r_cnt == 32'd1)
                        r_done <= slot_onehot(r_cur_slot);
                  end
               end
               GAP: begin
                  if (r_cnt == '0) begin
                     r_state <= IDLE;
                     r_beep  <= music_beep;
                  end else begin
                     r_cnt  <= r_cnt - 32'd1;
                     r_beep <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_beep  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sfx_ack  = r_ack;
   assign sfx_done = r_done;
   assign sfx_busy = (r_state != IDLE);
   assign beep     = r_beep;

endmodule

// File: tb/tb_beep_arbiter.sv
// Bench for beep_arbiter: directed scenarios plus random traffic against a
// timeline model (elapsed cycles since grant) of the arbiter.
module tb_beep_arbiter;

   localparam int DUR  = 64;
   localparam int GAPC = 8;
   localparam int SH   = 12;
`ifdef BEEP_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       mute;
   logic       music_beep;
   logic [3:0] sfx_req;
   logic [3:0] sfx_ack;
   logic [3:0] sfx_done;
   logic       sfx_busy;
   logic       beep;

   always #5 clk = ~clk;

   beep_arbiter #(
      .SFX_DUR_CYC      (DUR),
      .GAP_CYCLES       (GAPC),
      .TONE_SCALE_SHIFT (SH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mute       (mute),
      .music_beep (music_beep),
      .sfx_req    (sfx_req),
      .sfx_ack    (sfx_ack),
      .sfx_done   (sfx_done),
      .sfx_busy   (sfx_busy),
      .beep       (beep)
   );

   // Tone periods in cycles: (100 MHz / note frequency) >> 12 for A4, G4, E4, C4
   int tone_p [4] = '{55, 62, 74, 93};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: m_e counts cycles since the grant (0 = ack, 1..DUR = play, then gap)
   bit       m_act;
   int       m_slot;
   int       m_e;
   bit [3:0] m_pend;
   bit [3:0] e_ack, e_done;
   bit       e_beep;

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 4;
   endfunction

   task automatic model_reset();
      m_act = 0; m_slot = 0; m_e = 0; m_pend = '0;
      e_ack = '0; e_done = '0; e_beep = 0;
   endtask

   task automatic model_step(input bit [3:0] req, input bit m, input bit mus);
      bit [3:0] nack, ndone, cand;
      bit       nbeep;
      int       p;
      nack = '0; ndone = '0; nbeep = 0;
      cand = m_pend | req;
      if (m) begin
         m_act = 0; m_pend = '0; m_e = 0;
      end else if (!m_act) begin
         m_pend = cand;
         if (cand != 0) begin
            m_slot = lowest(cand); m_act = 1; m_e = 0; nack[m_slot] = 1;
         end else
            nbeep = mus;
      end else if (m_e == 0) begin
         m_pend = (m_pend & ~(4'b0001 << m_slot)) | req;
         m_e = 1;
      end else if (m_e <= DUR) begin
         m_pend = cand;
         p = tone_p[m_slot];
         if (PREEMPT && m_e < DUR && lowest(cand) < m_slot) begin
            m_slot = lowest(cand); m_e = 0; nack[m_slot] = 1;
         end else if (m_e == DUR) begin
            if (GAPC == 0) begin m_act = 0; nbeep = mus; end
            else m_e++;
         end else begin
            nbeep = ((m_e - 1) % p) >= (p / 2);
            if (m_e + 1 == DUR) ndone[m_slot] = 1;
            m_e++;
         end
      end else begin
         m_pend = cand;
         if (m_e == DUR + GAPC) begin m_act = 0; nbeep = mus; end
         else m_e++;
      end
      e_ack = nack; e_done = ndone; e_beep = nbeep;
   endtask

   int cyc = 0;
   int last_ack [4];
   int last_done [4];
   int done_cnt [4];
   int busy_fall = -1;
   bit prev_busy = 0;

   task automatic cyc_step(input logic [3:0] req, input logic m, input logic mus);
      sfx_req = req; mute = m; music_beep = mus;
      model_step(req, m, mus);
      @(posedge clk); #1;
      cyc++;
      chk_eq("ack",  32'(sfx_ack),  32'(e_ack));
      chk_eq("done", 32'(sfx_done), 32'(e_done));
      chk_eq("busy", 32'(sfx_busy), 32'(m_act));
      chk_eq("beep", 32'(beep),     32'(e_beep));
      for (int s = 0; s < 4; s++) begin
         if (sfx_ack[s]) last_ack[s] = cyc;
         if (sfx_done[s]) begin last_done[s] = cyc; done_cnt[s]++; end
      end
      if (prev_busy && !sfx_busy) busy_fall = cyc;
      prev_busy = sfx_busy;
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq(tag, {24'd0, sfx_ack, sfx_done}, 32'd0);
      chk_eq(tag, {30'd0, sfx_busy, beep}, 32'd0);
   endtask

   initial begin
      int t, t2, hi, d0, d3, mute_left;
      logic mus;
      logic [3:0] rq;
      logic mm;
      for (int s = 0; s < 4; s++) begin last_ack[s] = -1; last_done[s] = -1; done_cnt[s] = 0; end
      rst = 1'b1; mute = 1'b0; music_beep = 1'b0; sfx_req = '0; mus = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_state");
      rst = 1'b0;

      // Single request on slot 2
      cyc_step(4'b0000, 0, 0);
      t = cyc; hi = 0;
      cyc_step(4'b0100, 0, 0);
      for (int i = 0; i < 80; i++) begin
         cyc_step(4'b0000, 0, 0);
         if (beep) hi++;
      end
      chk_eq("single_ack_lat", 32'(last_ack[2]), 32'(t + 1));
      chk_eq("single_done_at", 32'(last_done[2]), 32'(last_ack[2] + DUR));
      chk_eq("single_busy_fall", 32'(busy_fall), 32'(last_ack[2] + 1 + DUR + GAPC));
      // P=74: count values 37..62 of 0..62 are high
      chk_eq("single_beep_high", 32'(hi), 32'd26);

      // Simultaneous slots 0 and 3
      t = cyc;
      cyc_step(4'b1001, 0, 0);
      for (int i = 0; i < 160; i++) cyc_step(4'b0000, 0, 0);
      chk_eq("simul_ack0", 32'(last_ack[0]), 32'(t + 1));
      chk_eq("simul_ack3", 32'(last_ack[3]), 32'(last_ack[0] + 1 + DUR + GAPC + 1));

      // Mute at play cycle 20 of slot 1
      t = cyc;
      cyc_step(4'b0010, 0, 0);
      while (cyc < t + 22) cyc_step(4'b0000, 0, 0);
      d0 = done_cnt[1];
      for (int i = 0; i < 12; i++) cyc_step((i % 2 == 1) ? 4'b1111 : 4'b0000, 1, 1);
      for (int i = 0; i < 20; i++) cyc_step(4'b0000, 0, 0);
      chk_eq("mute_no_done", 32'(done_cnt[1]), 32'(d0));
      chk_eq("mute_req_ignored", 32'(sfx_busy), 32'd0);

      // Music passthrough, then blocked during a play
      for (int i = 0; i < 120; i++) begin
         mus = (i % 3 == 0) ? ~mus : mus;
         cyc_step((i == 20) ? 4'b0001 : 4'b0000, 0, mus);
      end

      // Slot 1 requested while slot 3 plays
      t = cyc;
      cyc_step(4'b1000, 0, 0);
      while (cyc < t + 12) cyc_step(4'b0000, 0, 0);
      d3 = done_cnt[3];
      t2 = cyc;
      cyc_step(4'b0010, 0, 0);
      for (int i = 0; i < 200; i++) cyc_step(4'b0000, 0, 0);
      if (PREEMPT) begin
         chk_eq("preempt_ack_lat", 32'(last_ack[1] - t2 <= 2 && last_ack[1] > t2), 32'd1);
         chk_eq("preempt_no_done3", 32'(done_cnt[3]), 32'(d3));
      end else begin
         chk_eq("nopreempt_done3", 32'(done_cnt[3]), 32'(d3 + 1));
         chk_eq("nopreempt_ack1", 32'(last_ack[1]), 32'(last_done[3] + GAPC + 2));
      end

      // Asynchronous reset in the middle of the gap
      t = cyc;
      cyc_step(4'b0001, 0, 0);
      while (cyc < t + 69) cyc_step(4'b0000, 0, 1);
      chk_eq("gap_busy", 32'(sfx_busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      prev_busy = 0;
      @(posedge clk); #1;
      chk_all_zero("rst_hold");
      rst = 1'b0;

      // Random traffic
      mute_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (mute_left == 0 && $urandom_range(0, 499) == 0) mute_left = $urandom_range(1, 12);
         mm = (mute_left > 0);
         if (mute_left > 0) mute_left--;
         rq = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 3) == 0) mus = ~mus;
         cyc_step(rq, mm, mus);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
